// File: rtl/t_sram_responder_pkg.sv
// Shared constants, word field positions and count encoding for the T-stream SRAM responder.
package t_sram_responder_pkg;

   localparam int GROUP_W    = 32;
   localparam int T_PER_WORD = 7;
   localparam int WORD_W     = 4 + T_PER_WORD * GROUP_W;
   localparam int PAY_W      = WORD_W - 4;
   localparam int DEPTH      = 64;
   localparam int ADDR_W     = 6;
   localparam int TSIZE_W    = 9;

   localparam int VALID_BIT  = WORD_W - 1;
   localparam int CNT_MSB    = WORD_W - 2;
   localparam int CNT_LSB    = WORD_W - 4;

   // A full word of 7 groups travels as 0 in the 3-bit count field.
   function automatic logic [2:0] enc_cnt(input logic [3:0] n);
      return (n == 4'd7) ? 3'd0 : n[2:0];
   endfunction

endpackage

// File: rtl/t_sram_responder_if.sv
// Request/send word bus between the data processor (master) and the SRAM responder (slave).
interface t_sram_responder_if;
   import t_sram_responder_pkg::*;

   logic              i_sram_request;
   logic [WORD_W-1:0] o_request_data;
   logic              i_sram_send;
   logic [WORD_W-1:0] i_send_data;

   modport master (
      output i_sram_request,
      output i_sram_send,
      output i_send_data,
      input  o_request_data
   );

   modport slave (
      input  i_sram_request,
      input  i_sram_send,
      input  i_send_data,
      output o_request_data
   );

endinterface

// File: rtl/t_sram_responder_sp_word_ram.sv
// Single-port synchronous word RAM, one-cycle read latency, contents survive reset.
module sp_word_ram
   import t_sram_responder_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [PAY_W-1:0]  wdata_i,
   output logic [PAY_W-1:0]  rdata_o
);

   logic [PAY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/t_sram_responder.sv
// T-stream SRAM responder: circular word buffer serving reads and accepting send write-backs.
// Optional T_SRAM_OVERRUN_CHECK_EN adds a sticky o_overrun flag.
module t_sram_responder
   import t_sram_responder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_init,
   input  logic [TSIZE_W-1:0] i_T_size,
   input  logic               i_host_we,
   input  logic [ADDR_W-1:0]  i_host_addr,
   input  logic [PAY_W-1:0]   i_host_data,
   t_sram_responder_if.slave  bus,
   output logic               o_busy
`ifdef T_SRAM_OVERRUN_CHECK_EN
   ,
   output logic               o_overrun
`endif
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W:0]   nwords_q, nwords_d;
   logic [2:0]        last_q, last_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              pend_q, pend_d;
   logic              acc_q, acc_d;
   logic [2:0]        acc_cnt_q, acc_cnt_d;
   logic [WORD_W-1:0] out_q, out_d;

   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [PAY_W-1:0]  ram_wdata, ram_rdata;

   logic run, start_acc, inflight, send, want, rd_go;
   logic rd_last, wr_last;
   logic unused_hdr;

   assign run       = (state_q == S_RUN);
   assign start_acc = !run && i_start;
   assign inflight  = pend_q || acc_q || out_q[VALID_BIT];
   assign send      = run && !i_init && bus.i_sram_send;
   // A held read always wins over a new request; new requests wait for idle.
   assign want      = run && !i_init && (pend_q || (bus.i_sram_request && !inflight));
   assign rd_go     = want && !send;
   assign rd_last   = ({1'b0, rd_ptr_q} == nwords_q - 1'b1);
   assign wr_last   = ({1'b0, wr_ptr_q} == nwords_q - 1'b1);
   assign unused_hdr = ^bus.i_send_data[WORD_W-1:PAY_W];

   always_comb begin
      state_d   = state_q;
      nwords_d  = nwords_q;
      last_d    = last_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      pend_d    = 1'b0;
      acc_d     = 1'b0;
      acc_cnt_d = acc_cnt_q;
      out_d     = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = rd_ptr_q;
      ram_wdata = bus.i_send_data[PAY_W-1:0];
      unique case (state_q)
         S_IDLE: begin
            ram_we    = i_host_we;
            ram_addr  = i_host_addr;
            ram_wdata = i_host_data;
            if (i_start) begin
               state_d  = S_RUN;
               nwords_d = (ADDR_W+1)'(({1'b0, i_T_size} + 10'd6) / 10'd7);
               last_d   = 3'(i_T_size % 9'd7);
               rd_ptr_d = '0;
               wr_ptr_d = '0;
            end
         end
         S_RUN: begin
            if (i_init) begin
               state_d  = S_IDLE;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
            end else begin
               pend_d = want && send;
               if (send) begin
                  ram_we   = 1'b1;
                  ram_addr = wr_ptr_q;
                  wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
               end
               if (rd_go) begin
                  ram_re    = 1'b1;
                  acc_d     = 1'b1;
                  acc_cnt_d = rd_last ? last_q : enc_cnt(4'd7);
                  rd_ptr_d  = rd_last ? '0 : rd_ptr_q + 1'b1;
               end
               if (acc_q) out_d = {1'b1, acc_cnt_q, ram_rdata};
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         nwords_q  <= '0;
         last_q    <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         pend_q    <= 1'b0;
         acc_q     <= 1'b0;
         acc_cnt_q <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         nwords_q  <= nwords_d;
         last_q    <= last_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         pend_q    <= pend_d;
         acc_q     <= acc_d;
         acc_cnt_q <= acc_cnt_d;
         out_q     <= out_d;
      end
   end

   sp_word_ram u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign bus.o_request_data = out_q;
   assign o_busy             = run;

`ifdef T_SRAM_OVERRUN_CHECK_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;
   logic        ovr_q;

   // Overrun: a send lands on a word this round has not read yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         ovr_q    <= 1'b0;
      end else if (start_acc) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         if (rd_go) rd_cnt_q <= rd_cnt_q + 1'b1;
         if (send) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q >= rd_cnt_q) ovr_q <= 1'b1;
         end
      end
   end

   assign o_overrun = ovr_q;
`else
   logic unused_start;
   assign unused_start = start_acc;
`endif

endmodule

// File: tb/tb_t_sram_responder.sv
// Directed bench for t_sram_responder: reads, wrap, back-to-back requests, collisions, init.
// Also exercises the overrun flag when T_SRAM_OVERRUN_CHECK_EN is defined.
module tb_t_sram_responder;
   import t_sram_responder_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               i_start, i_init;
   logic [TSIZE_W-1:0] i_T_size;
   logic               i_host_we;
   logic [ADDR_W-1:0]  i_host_addr;
   logic [PAY_W-1:0]   i_host_data;
   logic               o_busy;
`ifdef T_SRAM_OVERRUN_CHECK_EN
   logic               o_overrun;
`endif

   int checks   = 0;
   int failures = 0;

   t_sram_responder_if bus ();

   t_sram_responder dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_init      (i_init),
      .i_T_size    (i_T_size),
      .i_host_we   (i_host_we),
      .i_host_addr (i_host_addr),
      .i_host_data (i_host_data),
      .bus         (bus),
      .o_busy      (o_busy)
`ifdef T_SRAM_OVERRUN_CHECK_EN
      ,
      .o_overrun   (o_overrun)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [PAY_W-1:0] pw(input logic [31:0] k);
      return {7{k}};
   endfunction

   function automatic logic [WORD_W-1:0] rsp(input logic [2:0] c,
                                             input logic [PAY_W-1:0] p);
      return {1'b1, c, p};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [WORD_W-1:0] got,
                      input logic [WORD_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start(input int ts);
      i_T_size = TSIZE_W'(ts);
      i_start  = 1'b1;
      tick();
      i_start  = 1'b0;
   endtask

   task automatic init_pulse();
      i_init = 1'b1;
      tick();
      i_init = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [WORD_W-1:0] exp);
      bus.i_sram_request = 1'b1;
      tick();
      bus.i_sram_request = 1'b0;
      tick();
      chk(tag, bus.o_request_data, exp);
      tick();
      chk({tag, "_clr"}, bus.o_request_data, '0);
      tick();
   endtask

   logic [PAY_W-1:0] w0, w1, w2, w3, q_pay, b_pay, x_pay;
   logic [WORD_W-1:0] e;

   initial begin
      w0    = pw(32'hC0DE_0000);
      w1    = pw(32'hC0DE_0001);
      w2    = pw(32'hC0DE_0002);
      w3    = pw(32'hC0DE_0003);
      q_pay = pw(32'h5EED_1234);
      b_pay = pw(32'hBEEF_0007);
      x_pay = pw(32'h0BAD_F00D);

      rst = 1'b1;
      i_start = 1'b0; i_init = 1'b0; i_T_size = '0;
      i_host_we = 1'b0; i_host_addr = '0; i_host_data = '0;
      bus.i_sram_request = 1'b0; bus.i_sram_send = 1'b0;
      bus.i_send_data = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("rst_data", bus.o_request_data, '0);
      chk("rst_busy", WORD_W'(o_busy), '0);
`ifdef T_SRAM_OVERRUN_CHECK_EN
      chk("rst_ovr", WORD_W'(o_overrun), '0);
`endif

      // preload four words
      i_host_we = 1'b1;
      i_host_addr = 6'd0; i_host_data = w0; tick();
      i_host_addr = 6'd1; i_host_data = w1; tick();
      i_host_addr = 6'd2; i_host_data = w2; tick();
      i_host_addr = 6'd3; i_host_data = w3; tick();
      i_host_we = 1'b0;

      // requests in IDLE are ignored
      bus.i_sram_request = 1'b1; tick();
      bus.i_sram_request = 1'b0; tick();
      chk("idle_req", bus.o_request_data, '0);
      tick();

      // test 1: T=17, three words, last count 3, wrap
      start(17);
      chk("t1_busy", WORD_W'(o_busy), WORD_W'(1));
      start(7);
      rd("t1_w0", rsp(3'd0, w0));
      rd("t1_w1", rsp(3'd0, w1));
      rd("t1_w2", rsp(3'd3, w2));
      rd("t1_wrap", rsp(3'd0, w0));

      init_pulse();
      chk("t1_idle", WORD_W'(o_busy), '0);

      // test 2: request held high, one valid every 3 cycles
      start(14);
      bus.i_sram_request = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2)      e = rsp(3'd0, w0);
         else if (i == 5) e = rsp(3'd0, w1);
         else if (i == 8) e = rsp(3'd0, w0);
         else             e = '0;
         chk($sformatf("t2_c%0d", i), bus.o_request_data, e);
      end
      bus.i_sram_request = 1'b0;
      tick();
      chk("t2_end", bus.o_request_data, '0);
      repeat (3) tick();
      init_pulse();

      // test 3: send collides with a read of word 1
      start(14);
      rd("t3_w0", rsp(3'd0, w0));
      bus.i_sram_request = 1'b1;
      bus.i_sram_send = 1'b1;
      bus.i_send_data = {4'hF, q_pay};
      tick();
      bus.i_sram_request = 1'b0;
      bus.i_sram_send = 1'b0;
      chk("t3_l1", bus.o_request_data, '0);
      tick();
      chk("t3_l2", bus.o_request_data, '0);
      tick();
      chk("t3_l3", bus.o_request_data, rsp(3'd0, w1));
      tick();
      chk("t3_l4", bus.o_request_data, '0);
      tick();
      rd("t3_mem0", rsp(3'd0, q_pay));
      init_pulse();

      // test 4: T=7 round trip
      start(7);
      rd("t4_a", rsp(3'd0, q_pay));
      bus.i_sram_send = 1'b1;
      bus.i_send_data = {4'h0, b_pay};
      tick();
      bus.i_sram_send = 1'b0;
      tick();
      rd("t4_b", rsp(3'd0, b_pay));
      init_pulse();

      // test 5: init right after a request drops it
      start(17);
      bus.i_sram_request = 1'b1;
      tick();
      bus.i_sram_request = 1'b0;
      i_init = 1'b1;
      tick();
      i_init = 1'b0;
      chk("t5_data", bus.o_request_data, '0);
      chk("t5_busy", WORD_W'(o_busy), '0);
      tick();
      chk("t5_data2", bus.o_request_data, '0);
      start(17);
      rd("t5_w0", rsp(3'd0, b_pay));
      init_pulse();

`ifdef T_SRAM_OVERRUN_CHECK_EN
      // test 6: overrun flag
      start(14);
      bus.i_sram_send = 1'b1;
      bus.i_send_data = {4'h0, x_pay};
      tick();
      bus.i_sram_send = 1'b0;
      chk("t6_ovr", WORD_W'(o_overrun), WORD_W'(1));
      tick();
      chk("t6_sticky", WORD_W'(o_overrun), WORD_W'(1));
      init_pulse();
      start(14);
      chk("t6_clr", WORD_W'(o_overrun), '0);
      rd("t6_rd", rsp(3'd0, x_pay));
      bus.i_sram_send = 1'b1;
      tick();
      bus.i_sram_send = 1'b0;
      chk("t6_ok", WORD_W'(o_overrun), '0);
      init_pulse();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
